// File: rtl/monitor_update_sequencer.sv
// Walks the position ROM and writes '0'/'1' characters for monitor bits that
// changed since the previous scan (or all of them on a full redraw).
module monitor_update_sequencer #(
  parameter int N_ENTRIES = 82,
  parameter int COL_W     = 7,
  parameter int ROW_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 force_all,
  input  logic [N_ENTRIES-1:0] mon_bits,
  output logic [9:0]           rom_addr,
  input  logic [31:0]          rom_data,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [COL_W-1:0]     wr_col,
  output logic [ROW_W-1:0]     wr_row,
  output logic [7:0]           wr_char,
  output logic                 busy,
  output logic                 done
);
  localparam int IW = $clog2(N_ENTRIES);

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, DONE} state_t;

  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [N_ENTRIES-1:0] snap_q, shadow_q;
  logic                 shadow_valid_q, full_q, pending_q, pending_force_q;
  logic [9:0]           rom_addr_q;
  logic                 wr_valid_q, busy_q, done_q;
  logic [COL_W-1:0]     wr_col_q;
  logic [ROW_W-1:0]     wr_row_q;
  logic [7:0]           wr_char_q;

  logic [IW-1:0] idx_d;
  logic          last, need_wr;

  assign idx_d   = idx_q + 1'b1;
  assign last    = (idx_q == IW'(N_ENTRIES - 1));
  assign need_wr = full_q | (snap_q[idx_q] != shadow_q[idx_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      snap_q          <= '0;
      shadow_q        <= '0;
      shadow_valid_q  <= 1'b0;
      full_q          <= 1'b0;
      pending_q       <= 1'b0;
      pending_force_q <= 1'b0;
      rom_addr_q      <= '0;
      wr_valid_q      <= 1'b0;
      wr_col_q        <= '0;
      wr_row_q        <= '0;
      wr_char_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Requests arriving mid-scan collapse into one rescan after DONE.
      if (start && (state_q == ADDR || state_q == WRITE)) begin
        pending_q       <= 1'b1;
        pending_force_q <= pending_force_q | force_all;
      end
      case (state_q)
        IDLE: if (start) begin
          snap_q     <= mon_bits;
          full_q     <= force_all | ~shadow_valid_q;
          idx_q      <= '0;
          rom_addr_q <= '0;
          busy_q     <= 1'b1;
          state_q    <= ADDR;
        end
        ADDR: begin
          if (need_wr) begin
            wr_col_q   <= rom_data[17:11];
            wr_row_q   <= rom_data[10:7];
            wr_char_q  <= 8'h30 | {7'd0, snap_q[idx_q]};
            wr_valid_q <= 1'b1;
            state_q    <= WRITE;
          end else if (last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q      <= idx_d;
            rom_addr_q <= 10'(idx_d);
          end
        end
        WRITE: if (wr_ready) begin
          wr_valid_q      <= 1'b0;
          shadow_q[idx_q] <= snap_q[idx_q];
          if (last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            idx_q      <= idx_d;
            rom_addr_q <= 10'(idx_d);
            state_q    <= ADDR;
          end
        end
        DONE: begin
          shadow_valid_q <= 1'b1;
          if (pending_q || start) begin
            snap_q          <= mon_bits;
            full_q          <= force_all | pending_force_q;
            pending_q       <= 1'b0;
            pending_force_q <= 1'b0;
            idx_q           <= '0;
            rom_addr_q      <= '0;
            busy_q          <= 1'b1;
            state_q         <= ADDR;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign wr_valid = wr_valid_q;
  assign wr_col   = wr_col_q;
  assign wr_row   = wr_row_q;
  assign wr_char  = wr_char_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_monitor_update_sequencer.sv
// Bench for monitor_update_sequencer: table-driven scans, hand-written corner
// sequences and randomized scans checked against a per-scan write-list model.
module tb_monitor_update_sequencer;
  localparam int N = 82;

  logic          clk = 0, rst = 1, start = 0, force_all = 0, wr_ready = 1;
  logic [N-1:0]  mon_bits = '0;
  logic [9:0]    rom_addr;
  logic [31:0]   rom_data;
  logic          wr_valid, busy, done;
  logic [6:0]    wr_col;
  logic [3:0]    wr_row;
  logic [7:0]    wr_char;

  monitor_update_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .force_all(force_all),
    .mon_bits(mon_bits), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col),
    .wr_row(wr_row), .wr_char(wr_char), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pcol(int i); return 7'((i * 5 + 1) % 128); endfunction
  function automatic logic [3:0] prow(int i); return 4'((i * 3) % 16); endfunction
  // Unused ROM bits carry junk so a wrong field slice shows up.
  assign rom_data = {14'h3A5C, pcol(int'(rom_addr)), prow(int'(rom_addr)), 7'h2B};

  typedef logic [18:0] rec_t;
  rec_t got[$];
  rec_t exp_q[$];
  int checks = 0, failures = 0;
  int stalls = 0, busy_cnt = 0, done_cnt = 0;
  int rmode = 0, stall_left = 0;
  logic [N-1:0] m_sh = '0;
  logic         m_sv = 0;

  // Monitor: collect handshakes and check hold-stable behaviour under backpressure.
  logic       prev_stall = 0;
  rec_t       prev_rec;
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        checks++;
        if (!(wr_valid && {wr_col, wr_row, wr_char} == prev_rec)) begin
          failures++;
          $display("FAIL stable: valid=%0b rec=%h required valid=1 rec=%h", wr_valid, {wr_col, wr_row, wr_char}, prev_rec);
        end
      end
      checks++;
      if (rom_addr >= N) begin
        failures++;
        $display("FAIL rom_range: rom_addr=%0d required <%0d", rom_addr, N);
      end
      if (wr_valid && wr_ready) got.push_back({wr_col, wr_row, wr_char});
      if (wr_valid && !wr_ready) stalls++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      prev_stall = wr_valid && !wr_ready;
      prev_rec   = {wr_col, wr_row, wr_char};
    end
  end

  // Backpressure driver: 0 always ready, 1 random, 2 five-cycle stall on write 3.
  always @(posedge clk) begin
    #1;
    if (rmode == 1) wr_ready = ($urandom_range(0, 2) != 0);
    else if (rmode == 2 && wr_valid && got.size() == 3 && stall_left > 0) begin
      wr_ready = 0;
      stall_left--;
    end else wr_ready = 1;
  end

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic model_scan(logic [N-1:0] mon, logic full_req);
    logic full = full_req | ~m_sv;
    for (int i = 0; i < N; i++)
      if (full || mon[i] != m_sh[i]) exp_q.push_back({pcol(i), prow(i), 8'h30 + 8'(mon[i])});
    m_sh = mon;
    m_sv = 1;
  endtask

  task automatic clear_obs();
    got.delete(); exp_q.delete();
    stalls = 0; busy_cnt = 0;
  endtask

  task automatic check_list(string name);
    int bad = -1;
    chk({name, ".count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (bad < 0 && got[i] != exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s.list: write %0d got %h required %h", name, bad, got[bad], exp_q[bad]);
    end
  endtask

  // Returns cycles from the start edge to the cycle in which done is high.
  task automatic wait_done(string name, output int n);
    n = 0;
    while (n < 3000) begin
      @(negedge clk); n++;
      if (done) break;
    end
    if (n >= 3000) chk({name, ".timeout"}, 0, 1);
  endtask

  task automatic run_scan(string name, logic [N-1:0] mon, logic f);
    int lat;
    @(negedge clk); #1;
    clear_obs();
    mon_bits = mon; force_all = f; start = 1;
    @(posedge clk); #1;
    start = 0; force_all = 0;
    model_scan(mon, f);
    wait_done(name, lat);
    check_list(name);
    chk({name, ".latency"}, lat, 1 + N + exp_q.size() + stalls);
    chk({name, ".busy_cycles"}, busy_cnt, lat - 1);
  endtask

  typedef struct { logic [N-1:0] mon; logic f; int exp_n; } vec_t;
  vec_t tbl[6];
  logic [N-1:0] ends, m;

  initial begin
    int n, d1, d2, dc0;
    ends = '0; ends[0] = 1; ends[N-1] = 1;
    tbl[0] = '{'0, 0, 82};
    tbl[1] = '{'0, 0, 0};
    tbl[2] = '{ends, 0, 2};
    tbl[3] = '{ends, 1, 82};
    tbl[4] = '{ends, 0, 0};
    tbl[5] = '{'1, 0, 80};

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_outputs", int'({rom_addr, wr_valid, wr_col, wr_row, wr_char, busy, done}), 0);

    for (int i = 0; i < 6; i++) begin
      run_scan($sformatf("tbl%0d", i), tbl[i].mon, tbl[i].f);
      chk($sformatf("tbl%0d.writes", i), got.size(), tbl[i].exp_n);
    end

    // Backpressure: five stalled cycles on the fourth write of an 8-write scan.
    rmode = 2; stall_left = 5;
    m = tbl[5].mon ^ {{(N-8){1'b0}}, 8'hFF};
    run_scan("stall", m, 0);
    chk("stall.cycles", stalls, 5);
    rmode = 0;

    // Two requests during a scan collapse into one forced rescan.
    @(negedge clk); #1;
    clear_obs(); dc0 = done_cnt;
    start = 1; force_all = 1;
    @(posedge clk); #1;
    start = 0; force_all = 0;
    model_scan(m, 1);
    model_scan(m, 1);
    n = 0; d1 = 0; d2 = 0;
    while (n < 1000 && d2 == 0) begin
      @(negedge clk); n++;
      if (done) begin if (d1 == 0) d1 = n; else d2 = n; end
      #1;
      start = (n == 10 || n == 20);
      force_all = (n == 20);
    end
    start = 0; force_all = 0;
    repeat (3) @(negedge clk);
    check_list("pending");
    chk("pending.done1", d1, 165);
    chk("pending.done2", d2 - d1, 165);
    chk("pending.done_pulses", done_cnt - dc0, 2);

    // Reset while entry 40 is waiting in WRITE.
    @(negedge clk); #1;
    clear_obs();
    mon_bits = '1; force_all = 1; start = 1;
    @(posedge clk); #1;
    start = 0; force_all = 0;
    n = 0;
    while (n < 1000 && !(wr_valid && rom_addr == 40)) begin @(negedge clk); #1; n++; end
    chk("rst.reached40", int'(n < 1000), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst.wr_valid", int'(wr_valid), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.rom_addr", int'(rom_addr), 0);
    @(negedge clk); #1 rst = 0;
    m_sh = '0; m_sv = 0;
    run_scan("post_rst", '1, 0);
    chk("post_rst.writes", got.size(), 82);

    // Randomized scans with sparse bit flips and random backpressure.
    rmode = 1;
    m = '1;
    for (int r = 0; r < 20; r++) begin
      int k = $urandom_range(0, 6);
      for (int j = 0; j < k; j++) m[$urandom_range(0, N-1)] ^= 1'b1;
      run_scan($sformatf("rand%0d", r), m, ($urandom_range(0, 3) == 0));
    end
    rmode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/monitor_update_sequencer.md
Name: monitor_update_sequencer

Overview:
- Drives the VGA character-monitor refresh for the MIPS debug display.
- On each trigger it snapshots the CPU monitor bit vector (PC, ALU, register-file and RAM fields, 82 bits total).
- It walks the position ROM at addresses 0..N_ENTRIES-1, reads each entry's {col,row} screen position, and writes an ASCII '0'/'1' character into the character buffer at that position.
- Bits that have not changed since the last scan are skipped unless a full redraw is requested.

Parameters:
- N_ENTRIES, 82, number of ROM entries and monitor bits scanned (addresses 0..81).
- COL_W, 7, column field width, taken from rom_data[17:11].
- ROW_W, 4, row field width, taken from rom_data[10:7].

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle scan request
- force_all  input  1  sampled with start; 1 means write every entry regardless of change
- mon_bits  input  N_ENTRIES  monitor vector; bit i is shown at ROM entry i
- rom_addr  output  10  position ROM address (ROM is combinational)
- rom_data  input  32  position ROM data; only bits [17:7] are used
- wr_valid  output  1  character write request
- wr_ready  input  1  character buffer accepts the write when wr_valid && wr_ready
- wr_col  output  COL_W  write column
- wr_row  output  ROW_W  write row
- wr_char  output  8  ASCII character, 8'h30 or 8'h31
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse when a scan completes

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high.
- Reset values: all outputs 0, including rom_addr, wr_* and busy/done. The FSM enters IDLE, the shadow register is cleared, shadow_valid=0 and pending=0.
- Reset mid-scan aborts immediately. Any outstanding wr_valid drops on the next edge, and the next scan is a full redraw.
- FSM states: IDLE, ADDR, WRITE, DONE.
- IDLE:
  - When start=1, latch snap<=mon_bits and full<=force_all|~shadow_valid, set idx<=0, and go to ADDR.
  - busy=1 from the next cycle.
- ADDR:
  - rom_addr=idx for one cycle. Column and row are registered from rom_data at the end of this cycle, so rom_data must be valid within the cycle.
  - If full or snap[idx]!=shadow[idx], go to WRITE.
  - Otherwise skip: if idx==N_ENTRIES-1 go to DONE, else idx<=idx+1 and stay in ADDR.
- WRITE:
  - wr_valid=1, wr_col/wr_row come from the registered ROM fields, wr_char=8'h30+snap[idx].
  - All wr_* outputs are held stable until wr_ready=1.
  - On handshake: shadow[idx]<=snap[idx]; then go to DONE if idx==N_ENTRIES-1, else idx<=idx+1 and go to ADDR.
  - wr_valid is never dropped without a handshake, except on reset.
- DONE:
  - done=1 for one cycle, shadow_valid<=1, busy=0 in the following cycle.
  - If pending=1, clear it and begin a new scan exactly as from IDLE, using mon_bits and force_all sampled in the DONE cycle. Otherwise go to IDLE.
- start while busy is not ignored: it sets pending<=1, and force_all is ORed into pending_force. Multiple requests collapse into a single rescan.
- Snapshot rule: mon_bits changes during a scan do not affect that scan. They are picked up only by the next start.
- Latency:
  - start at edge T gives ADDR(idx 0) in cycle T+1 and the first wr_valid in T+2.
  - With wr_ready held at 1 and all entries written, each entry takes 2 cycles, so done is asserted in cycle T+1+2*N_ENTRIES (T+165).
  - An all-skip scan takes 1 cycle per entry, so done is at T+1+N_ENTRIES.
- rom_addr holds its last value outside ADDR and is reset to 0. ROM addresses >= N_ENTRIES are never issued.

Test Plan:
- Reset, then start with force_all=0 and mon_bits=0, wr_ready=1 -> first scan is full: 82 writes, all wr_char=8'h30, positions matching the ROM in order 0..81, done at T+165.
- Second start with mon_bits unchanged -> zero writes, done at T+83, busy high for 82 cycles.
- Set only mon_bits[0] (PC3) and [81] (RAMWEN) to 1, then start -> exactly 2 writes, both 8'h31, at the positions of entries 0 and 81 respectively.
- wr_ready low for 5 cycles during write 3 -> wr_valid, col, row and char stay stable; no entry is lost or duplicated; done is delayed by exactly 5 cycles.
- Pulse start at cycles 10 and 20 during an active scan, with force_all=1 on the second pulse -> one extra full 82-write scan starts right after the first done; two done pulses total.
- Assert rst mid-WRITE at entry 40 -> wr_valid=0 and busy=0 next cycle; the next start performs a full 82-write redraw even with force_all=0.
